// File: rtl/pynq_audio_pkg.sv
// Shared audio-path definitions.
//   FRAME_LEN : samples per windowed input frame
//   HOP_LEN   : output samples per frame (FRAME_LEN/2)
//   SAMPLE_W  : signed two's-complement sample width
//   sample_t  : signed sample type at SAMPLE_W bits
//   phase_t   : overlap-add phase, numerically equal to the frame index MSB
package pynq_audio_pkg;

  localparam int FRAME_LEN = 1024;
  localparam int HOP_LEN   = FRAME_LEN / 2;
  localparam int SAMPLE_W  = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    PH_ADD   = 1'b0,
    PH_STORE = 1'b1
  } phase_t;

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream style valid/ready interface.
//   valid : producer has a beat on data
//   ready : consumer can take the beat this cycle
//   data  : DATA_W-bit payload
interface Axis_If #(
  parameter int DATA_W = 16
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport Master (output valid, output data, input  ready);
  modport Slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/overlap_tail_ram.sv
// Tail storage for overlap-add: simple dual-port RAM, synchronous write,
// synchronous one-cycle read, no reset so it maps onto block RAM.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (registered into rdata on the next edge)
//   rdata : read data
module overlap_tail_ram #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/overlap_add_buffer.sv
// 50% overlap-add reconstruction buffer.
// The first half of each frame (ADD) is summed with the tail stored from the
// previous frame's second half and emitted with saturation; the second half
// (STORE) is written into the tail RAM and produces no output.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   din     : windowed input frames (valid/ready, SAMPLE_W data)
//   dout    : reconstructed output stream (valid/ready, SAMPLE_W data)
module overlap_add_buffer #(
  parameter int FRAME_LEN = pynq_audio_pkg::FRAME_LEN,
  parameter int HOP_LEN   = pynq_audio_pkg::HOP_LEN,
  parameter int SAMPLE_W  = pynq_audio_pkg::SAMPLE_W
) (
  input  logic   clk,
  input  logic   reset_n,
  Axis_If.Slave  din,
  Axis_If.Master dout
);

  import pynq_audio_pkg::phase_t;
  import pynq_audio_pkg::PH_ADD;
  import pynq_audio_pkg::PH_STORE;

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam int HOP_W = $clog2(HOP_LEN);

  logic [IDX_W-1:0]    idx;
  phase_t              phase;
  logic                first_frame;
  logic                out_valid;
  logic [SAMPLE_W-1:0] out_data;

  logic                din_ready;
  logic                accept;
  logic                add_fire;
  logic                store_fire;
  logic [HOP_W-1:0]    rd_addr;
  logic [SAMPLE_W-1:0] tail_q;
  logic [SAMPLE_W-1:0] tail_val;
  logic [SAMPLE_W:0]   sum;
  logic [SAMPLE_W-1:0] sat;

  always_comb begin
    phase      = phase_t'(idx[IDX_W-1]);
    din_ready  = (phase == PH_STORE) || !out_valid || dout.ready;
    accept     = din.valid && din_ready;
    add_fire   = accept && (phase == PH_ADD);
    store_fire = accept && (phase == PH_STORE);
  end

  // Read address tracks the index the *next* cycle will present, so tail_q
  // always holds tail[idx] and back-to-back ADD beats need no stall. The
  // write address in STORE is never the read address: a pending write sits at
  // idx while the read targets idx+1 (or idx when nothing is accepted).
  always_comb begin
    rd_addr = accept ? (idx[HOP_W-1:0] + 1'b1) : idx[HOP_W-1:0];
  end

  overlap_tail_ram #(
    .DEPTH (HOP_LEN),
    .WIDTH (SAMPLE_W)
  ) u_tail_ram (
    .clk   (clk),
    .we    (store_fire),
    .waddr (idx[HOP_W-1:0]),
    .wdata (din.data),
    .raddr (rd_addr),
    .rdata (tail_q)
  );

  // RAM is never cleared; the first frame after reset sees a zero tail.
  always_comb begin
    tail_val = first_frame ? '0 : tail_q;
    sum      = {din.data[SAMPLE_W-1], din.data} + {tail_val[SAMPLE_W-1], tail_val};
    case (sum[SAMPLE_W -: 2])
      2'b01:   sat = {1'b0, {(SAMPLE_W-1){1'b1}}};
      2'b10:   sat = {1'b1, {(SAMPLE_W-1){1'b0}}};
      default: sat = sum[SAMPLE_W-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx         <= '0;
      first_frame <= 1'b1;
      out_valid   <= 1'b0;
      out_data    <= '0;
    end else begin
      if (accept) begin
        idx <= idx + 1'b1;
      end
      if (store_fire && (&idx)) begin
        first_frame <= 1'b0;
      end
      if (add_fire) begin
        out_valid <= 1'b1;
        out_data  <= sat;
      end else if (dout.ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign din.ready  = din_ready;
  assign dout.valid = out_valid;
  assign dout.data  = out_data;

endmodule

// File: doc/overlap_add_buffer.md
OVERLAP_ADD_BUFFER -- requirements
Module: overlap_add_buffer

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 1024: samples per input frame.
REQ-002 SHALL have parameter HOP_LEN, default 512: output samples per frame, fixed at FRAME_LEN/2.
REQ-003 SHALL have parameter SAMPLE_W, default 16: signed two's-complement sample width.
REQ-004 SHALL have port clk  input  1: single clock; all logic on the rising edge.
REQ-005 SHALL have port reset_n  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port din  Axis_If.Slave  SAMPLE_W data: windowed time-domain frames, valid/ready handshake.
REQ-007 SHALL have port dout  Axis_If.Master  SAMPLE_W data: continuous reconstructed stream, valid/ready handshake.

Function
REQ-008 SHALL count accepted din samples (din.valid && din.ready) in a log2(FRAME_LEN)-bit index.
- Wrap FRAME_LEN-1 -> 0.
- Frame boundary is implied by the index; there is no last signal.
REQ-009 SHALL operate in two phases selected by the index MSB:
- ADD: index < HOP_LEN.
- STORE: index >= HOP_LEN.
REQ-010 In ADD, for each accepted sample x[i], it SHALL compute y = x[i] + tail[i] at SAMPLE_W+1 bits, saturate to SAMPLE_W signed range, and emit y on dout.
REQ-011 In STORE, it SHALL write the accepted sample into tail[index-HOP_LEN]; no dout beat is produced.
REQ-012 din.ready SHALL be (!dout.valid || dout.ready) in ADD, and 1 in STORE.
REQ-013 dout.data/dout.valid SHALL be registered, giving one-cycle latency from an accepted ADD sample to dout.valid.
REQ-014 dout.valid SHALL hold, with dout.data stable, until dout.ready; a new beat may load in the same cycle the old one is taken.
REQ-015 The tail RAM read SHALL be prefetched for the next ADD index so that back-to-back ADD samples sustain one beat per cycle with no bubbles.
REQ-016 For the first frame after reset, tail SHALL read as zero; a first_frame flag clears on the first STORE write at index FRAME_LEN-1.
REQ-017 Saturation limits: sums > 2^(SAMPLE_W-1)-1 clamp to 32767; sums < -2^(SAMPLE_W-1) clamp to -32768 (SAMPLE_W=16).
REQ-018 On a stalled dout in ADD, din SHALL be back-pressured; no sample is dropped or duplicated.
REQ-019 Index wrap STORE->ADD SHALL occur with no idle cycle.

Reset
REQ-020 reset_n low SHALL asynchronously force: index=0, phase=ADD, first_frame=1, dout.valid=0, dout.data=0.
REQ-021 Tail RAM contents SHALL NOT be cleared; first_frame masks them.
REQ-022 Reset mid-frame SHALL discard the partial frame and any pending dout beat; operation restarts at index 0 after reset_n rises.

Structure
REQ-023 FRAME_LEN, HOP_LEN and SAMPLE_W defaults, plus a sample_t typedef (signed [SAMPLE_W-1:0]), SHALL live in shared package pynq_audio_pkg.
REQ-024 Tail storage SHALL be sub-module overlap_tail_ram:
- HOP_LEN x SAMPLE_W, simple dual-port.
- Synchronous one-cycle read, synchronous write.
- Inferable as block RAM.

Verification
REQ-025 First frame after reset: frame of 1024 samples all 100, dout always ready -> 512 outputs of 100, no outputs during STORE.
REQ-026 Steady state: second frame of all 200 -> 512 outputs of 300 (200+100); third frame value = index -> outputs i+200 for i=0..511.
REQ-027 Saturation: tail 30000, input 10000 -> 32767; tail -30000, input -10000 -> -32768.
REQ-028 Backpressure: dout.ready toggling at random 50% over 3 frames -> output sequence identical to the always-ready run; din.ready low exactly when dout.valid && !dout.ready in ADD.
REQ-029 Throughput: continuous din.valid and dout.ready -> one din beat per cycle across the index 1023->0 wrap, and 512 consecutive dout beats per frame.
REQ-030 Reset mid-frame: assert reset_n low at index 700 of frame 2 -> dout.valid=0 immediately; the next frame of all 50 outputs 50 (tail masked).
